snitch_icache_refill_arbiter: RTL and testbench

SNITCH_ICACHE_REFILL_ARBITER -- requirements
Module: snitch_icache_refill_arbiter

---
 rtl/snitch_icache_pkg.sv | 15 +
 rtl/snitch_icache_refill_arbiter_rr.sv | 35 +++
 rtl/snitch_icache_refill_arbiter.sv | 126 ++++++++++++
 tb/tb_snitch_icache_refill_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snitch_icache_pkg.sv
// snitch_icache_pkg: ID-bit encoding shared by the L0 refill path.
// Each port p owns two ID bits: 2*p marks a demand refill, 2*p+1 a prefetch.
package snitch_icache_pkg;

  localparam int unsigned ID_BITS_PER_PORT = 2;
  localparam int unsigned ID_REFILL_BIT    = 0;
  localparam int unsigned ID_PREFETCH_BIT  = 1;
  localparam int unsigned MAX_ID_WIDTH     = 32;

  function automatic logic [MAX_ID_WIDTH-1:0] port_id_mask(input int unsigned port);
    return ((MAX_ID_WIDTH'(1) << ID_REFILL_BIT) | (MAX_ID_WIDTH'(1) << ID_PREFETCH_BIT))
           << (ID_BITS_PER_PORT * port);
  endfunction

endpackage

// File: rtl/snitch_icache_refill_arbiter_rr.sv
// snitch_icache_refill_arbiter_rr: round-robin picker with an external pointer.
// Ports: i_valid  - request vector
//        i_rr     - port with highest priority this cycle
//        o_idx    - first valid port at or after i_rr, wrapping
//        o_found  - any request valid
module snitch_icache_refill_arbiter_rr #(
  parameter int unsigned NR_PORTS = 4,
  parameter int unsigned IW       = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
  input  logic [NR_PORTS-1:0] i_valid,
  input  logic [IW-1:0]       i_rr,
  output logic [IW-1:0]       o_idx,
  output logic                o_found
);

  logic [IW-1:0]       w_cand [NR_PORTS];
  logic [IW-1:0]       w_acc  [NR_PORTS+1];
  logic [NR_PORTS-1:0] w_hit;
  logic [NR_PORTS-1:0] w_first;

  // w_hit is the request vector rotated so offset 0 is the priority port;
  // isolating its lowest set bit picks the winning offset.
  assign w_first  = w_hit & (~w_hit + 1'b1);
  assign w_acc[0] = '0;

  for (genvar o = 0; o < NR_PORTS; o++) begin : g_off
    assign w_cand[o]  = IW'((i_rr + o) % NR_PORTS);
    assign w_hit[o]   = i_valid[w_cand[o]];
    assign w_acc[o+1] = w_acc[o] | (w_first[o] ? w_cand[o] : '0);
  end

  assign o_idx   = w_acc[NR_PORTS];
  assign o_found = |i_valid;

endmodule

// File: rtl/snitch_icache_refill_arbiter.sv
// snitch_icache_refill_arbiter: round-robin arbiter of L0 refill requests onto one
// refill port, with combinational ID-based response demultiplexing.
// Option: define SNITCH_ICACHE_REFILL_MERGE_EN to also grant, in the accepting
//         cycle, every valid port whose address equals the winner's (IDs OR-ed).
// Ports: clk_i, rst_i           - clock, synchronous active-high reset
//        in_req_*               - per-port requests (flattened, port 0 in LSBs)
//        in_rsp_*               - per-port responses (data/error broadcast)
//        out_req_*              - registered refill request
//        out_rsp_*              - refill response from the next level
module snitch_icache_refill_arbiter
  import snitch_icache_pkg::*;
#(
  parameter int unsigned NR_PORTS   = 4,
  parameter int unsigned FETCH_AW   = 32,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned ID_WIDTH   = 2 * NR_PORTS
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NR_PORTS*FETCH_AW-1:0]   in_req_addr_i,
  input  logic [NR_PORTS*ID_WIDTH-1:0]   in_req_id_i,
  input  logic [NR_PORTS-1:0]            in_req_valid_i,
  output logic [NR_PORTS-1:0]            in_req_ready_o,
  output logic [LINE_WIDTH-1:0]          in_rsp_data_o,
  output logic                           in_rsp_error_o,
  output logic [NR_PORTS*ID_WIDTH-1:0]   in_rsp_id_o,
  output logic [NR_PORTS-1:0]            in_rsp_valid_o,
  input  logic [NR_PORTS-1:0]            in_rsp_ready_i,
  output logic [FETCH_AW-1:0]            out_req_addr_o,
  output logic [ID_WIDTH-1:0]            out_req_id_o,
  output logic                           out_req_valid_o,
  input  logic                           out_req_ready_i,
  input  logic [LINE_WIDTH-1:0]          out_rsp_data_i,
  input  logic                           out_rsp_error_i,
  input  logic [ID_WIDTH-1:0]            out_rsp_id_i,
  input  logic                           out_rsp_valid_i,
  output logic                           out_rsp_ready_o
);

  localparam int unsigned IW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

  logic                r_valid;
  logic [FETCH_AW-1:0] r_addr;
  logic [ID_WIDTH-1:0] r_id;
  logic [IW-1:0]       r_rr;

  logic [FETCH_AW-1:0] w_addr [NR_PORTS];
  logic [ID_WIDTH-1:0] w_id   [NR_PORTS];
  logic [ID_WIDTH-1:0] w_mask [NR_PORTS];
  logic [ID_WIDTH-1:0] w_gid  [NR_PORTS+1];
  logic [NR_PORTS-1:0] w_grant;
  logic [NR_PORTS-1:0] w_rsp_hit;
  logic [IW-1:0]       w_win;
  logic [FETCH_AW-1:0] w_win_addr;
  logic                w_found;
  logic                w_accept;

  snitch_icache_refill_arbiter_rr #(
    .NR_PORTS (NR_PORTS),
    .IW       (IW)
  ) i_rr (
    .i_valid (in_req_valid_i),
    .i_rr    (r_rr),
    .o_idx   (w_win),
    .o_found (w_found)
  );

  assign w_win_addr = w_addr[w_win];
  assign w_gid[0]   = '0;

  for (genvar p = 0; p < NR_PORTS; p++) begin : g_port
    assign w_addr[p]    = in_req_addr_i[p*FETCH_AW +: FETCH_AW];
    assign w_id[p]      = in_req_id_i[p*ID_WIDTH +: ID_WIDTH];
    assign w_mask[p]    = ID_WIDTH'(port_id_mask(p));
    assign w_rsp_hit[p] = |(out_rsp_id_i & w_mask[p]);
    assign in_rsp_valid_o[p] = out_rsp_valid_i & w_rsp_hit[p];
    assign in_rsp_id_o[p*ID_WIDTH +: ID_WIDTH] = out_rsp_id_i & w_mask[p];
`ifdef SNITCH_ICACHE_REFILL_MERGE_EN
    assign w_grant[p] = w_found & in_req_valid_i[p] & (w_addr[p] == w_win_addr);
`else
    assign w_grant[p] = w_found & (w_win == IW'(p));
`endif
    assign w_gid[p+1] = w_gid[p] | (w_grant[p] ? w_id[p] : '0);
  end

  // A reset cycle never grants: the register is being cleared underneath it.
  assign w_accept       = w_found & (~r_valid | out_req_ready_i) & ~rst_i;
  assign in_req_ready_o = w_accept ? w_grant : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_rr    <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_rr    <= (w_win == IW'(NR_PORTS - 1)) ? '0 : w_win + 1'b1;
    end else if (out_req_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_addr <= w_win_addr;
      r_id   <= w_gid[NR_PORTS];
    end
  end

  assign out_req_valid_o = r_valid;
  assign out_req_addr_o  = r_addr;
  assign out_req_id_o    = r_id;

  // Ports not addressed by the response do not hold it back; with no port
  // addressed the beat is simply consumed.
  assign in_rsp_data_o   = out_rsp_data_i;
  assign in_rsp_error_o  = out_rsp_error_i;
  assign out_rsp_ready_o = &(in_rsp_ready_i | ~w_rsp_hit);

  stable_while_stalled: assert property (@(posedge clk_i) disable iff (rst_i)
    r_valid && !out_req_ready_i |=> r_valid && $stable(r_addr) && $stable(r_id));

`ifndef SNITCH_ICACHE_REFILL_MERGE_EN
  single_grant: assert property (@(posedge clk_i) $onehot0(in_req_ready_o));
`endif

endmodule

// File: tb/tb_snitch_icache_refill_arbiter.sv
// tb_snitch_icache_refill_arbiter: directed scenarios plus randomized scoreboard run.
module tb_snitch_icache_refill_arbiter;

  localparam int N = 4, AW = 32, LW = 128, IDW = 8;
`ifdef SNITCH_ICACHE_REFILL_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N*AW-1:0]  in_req_addr_i = '0;
  logic [N*IDW-1:0] in_req_id_i = '0;
  logic [N-1:0]     in_req_valid_i = '0;
  logic [N-1:0]     in_req_ready_o;
  logic [LW-1:0]    in_rsp_data_o;
  logic             in_rsp_error_o;
  logic [N*IDW-1:0] in_rsp_id_o;
  logic [N-1:0]     in_rsp_valid_o;
  logic [N-1:0]     in_rsp_ready_i = '0;
  logic [AW-1:0]    out_req_addr_o;
  logic [IDW-1:0]   out_req_id_o;
  logic             out_req_valid_o;
  logic             out_req_ready_i = 1'b0;
  logic [LW-1:0]    out_rsp_data_i = '0;
  logic             out_rsp_error_i = 1'b0;
  logic [IDW-1:0]   out_rsp_id_i = '0;
  logic             out_rsp_valid_i = 1'b0;
  logic             out_rsp_ready_o;

  always #5 clk = ~clk;

  snitch_icache_refill_arbiter #(.NR_PORTS(N), .FETCH_AW(AW), .LINE_WIDTH(LW)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_req_addr_i(in_req_addr_i), .in_req_id_i(in_req_id_i),
    .in_req_valid_i(in_req_valid_i), .in_req_ready_o(in_req_ready_o),
    .in_rsp_data_o(in_rsp_data_o), .in_rsp_error_o(in_rsp_error_o),
    .in_rsp_id_o(in_rsp_id_o), .in_rsp_valid_o(in_rsp_valid_o),
    .in_rsp_ready_i(in_rsp_ready_i),
    .out_req_addr_o(out_req_addr_o), .out_req_id_o(out_req_id_o),
    .out_req_valid_o(out_req_valid_o), .out_req_ready_i(out_req_ready_i),
    .out_rsp_data_i(out_rsp_data_i), .out_rsp_error_i(out_rsp_error_i),
    .out_rsp_id_i(out_rsp_id_i), .out_rsp_valid_i(out_rsp_valid_i),
    .out_rsp_ready_o(out_rsp_ready_o)
  );

  typedef struct {
    logic           vld;
    logic [N-1:0]   rdy;
    logic [N-1:0]   rv;
    logic [N*IDW-1:0] rid;
    logic           rr;
    logic [LW-1:0]  data;
    logic           err;
  } cyc_t;
  typedef struct {
    logic [AW-1:0]  addr;
    logic [IDW-1:0] id;
  } req_t;

  cyc_t cyc_q[$];
  req_t req_q[$];
  int   n_cmp = 0, n_err = 0;
  int   m_rr = 0, m_held = 0;
  logic sb_en = 1'b0;

  task automatic cmp(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic [AW-1:0] a, input logic [IDW-1:0] id);
    in_req_valid_i[p] = v;
    in_req_addr_i[p*AW +: AW] = a;
    in_req_id_i[p*IDW +: IDW] = id;
  endtask

  // Monitor: pops the per-cycle expectation and, while a request is presented,
  // compares it against the oldest accepted request, retiring it on handshake.
  always @(negedge clk) begin : mon
    cyc_t c;
    if (sb_en) begin
      if (cyc_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL sb_cycle: got empty expectation queue expected an entry");
      end else begin
        c = cyc_q.pop_front();
        cmp("sb_out_valid", LW'(out_req_valid_o), LW'(c.vld));
        cmp("sb_in_ready", LW'(in_req_ready_o), LW'(c.rdy));
        cmp("sb_rsp_valid", LW'(in_rsp_valid_o), LW'(c.rv));
        cmp("sb_rsp_id", LW'(in_rsp_id_o), LW'(c.rid));
        cmp("sb_rsp_ready", LW'(out_rsp_ready_o), LW'(c.rr));
        cmp("sb_rsp_data", in_rsp_data_o, c.data);
        cmp("sb_rsp_error", LW'(in_rsp_error_o), LW'(c.err));
      end
      if (out_req_valid_o) begin
        if (req_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL sb_req: got request %0h with none outstanding expected none", out_req_addr_o);
        end else begin
          cmp("sb_req_addr", LW'(out_req_addr_o), LW'(req_q[0].addr));
          cmp("sb_req_id", LW'(out_req_id_o), LW'(req_q[0].id));
          if (out_req_ready_i) void'(req_q.pop_front());
        end
      end
    end
  end

  // One random cycle: drive inputs, predict from the arbitration rules, push.
  task automatic rand_cycle(input bit drain);
    logic [N-1:0]   v;
    logic [AW-1:0]  a [N];
    logic [IDW-1:0] id [N];
    logic [N-1:0]   g;
    logic           acc, hit;
    int             w;
    req_t           r;
    cyc_t           c;
    @(posedge clk); #1;
    for (int p = 0; p < N; p++) begin
      v[p]  = drain ? 1'b0 : 1'($urandom_range(0, 1));
      a[p]  = 32'h8000_0000 + 32'($urandom_range(0, 2)) * 32'd64;
      id[p] = IDW'($urandom_range(1, 3)) << (2 * p);
      set_req(p, v[p], a[p], id[p]);
      in_rsp_ready_i[p] = ($urandom_range(0, 3) != 0);
    end
    out_req_ready_i = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
    out_rsp_id_i    = IDW'($urandom);
    out_rsp_valid_i = 1'($urandom_range(0, 1));
    out_rsp_data_i  = {$urandom, $urandom, $urandom, $urandom};
    out_rsp_error_i = 1'($urandom_range(0, 1));
    w = -1;
    for (int k = 0; k < N; k++) if (w < 0 && v[(m_rr + k) % N]) w = (m_rr + k) % N;
    acc = (w >= 0) && (m_held == 0 || out_req_ready_i);
    g = '0;
    r.addr = '0;
    r.id = '0;
    if (acc) begin
      r.addr = a[w];
      for (int p = 0; p < N; p++)
        if (v[p] && (p == w || (MERGE && a[p] == a[w]))) begin
          g[p] = 1'b1;
          r.id |= id[p];
        end
    end
    c.vld = (m_held != 0);
    c.rdy = g;
    c.rr = 1'b1;
    c.rid = '0;
    for (int p = 0; p < N; p++) begin
      hit = |out_rsp_id_i[2*p +: 2];
      c.rv[p] = out_rsp_valid_i && hit;
      c.rid[p*IDW +: IDW] = out_rsp_id_i & (IDW'(3) << (2 * p));
      if (hit && !in_rsp_ready_i[p]) c.rr = 1'b0;
    end
    c.data = out_rsp_data_i;
    c.err = out_rsp_error_i;
    cyc_q.push_back(c);
    if (acc) begin
      req_q.push_back(r);
      m_held = 1;
      m_rr = (w + 1) % N;
    end else if (out_req_ready_i) begin
      m_held = 0;
    end
    sb_en = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    cmp("reset_out_valid", LW'(out_req_valid_o), '0);
    cmp("reset_in_ready", LW'(in_req_ready_o), '0);
    cmp("reset_rr", LW'(dut.r_rr), '0);

    // Round-robin: ports 0 and 2 compete from pointer 0.
    @(posedge clk); #1;
    out_req_ready_i = 1'b1;
    set_req(0, 1'b1, 32'h100, 8'h01);
    set_req(2, 1'b1, 32'h200, 8'h10);
    @(negedge clk);
    cmp("rr_grant0", LW'(in_req_ready_o), LW'(4'b0001));
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h100, 8'h01);
    @(negedge clk);
    cmp("rr_grant2", LW'(in_req_ready_o), LW'(4'b0100));
    cmp("rr_req0_addr", LW'(out_req_addr_o), LW'(32'h100));
    cmp("rr_req0_id", LW'(out_req_id_o), LW'(8'h01));
    @(posedge clk); #1;
    set_req(2, 1'b0, 32'h200, 8'h10);
    @(negedge clk);
    cmp("rr_req2_addr", LW'(out_req_addr_o), LW'(32'h200));
    cmp("rr_req2_id", LW'(out_req_id_o), LW'(8'h10));
    cmp("rr_ptr", LW'(dut.r_rr), LW'(3));

    // Stall: register held for five cycles while every port requests.
    @(posedge clk); #1;
    out_req_ready_i = 1'b0;
    set_req(1, 1'b1, 32'h300, 8'h08);
    @(negedge clk);
    cmp("stall_fill_grant", LW'(in_req_ready_o), LW'(4'b0010));
    @(posedge clk); #1;
    for (int p = 0; p < N; p++) set_req(p, 1'b1, 32'h400 + 32'(p), IDW'(1) << (2 * p));
    repeat (5) begin
      @(negedge clk);
      cmp("stall_valid", LW'(out_req_valid_o), LW'(1));
      cmp("stall_addr", LW'(out_req_addr_o), LW'(32'h300));
      cmp("stall_id", LW'(out_req_id_o), LW'(8'h08));
      cmp("stall_ready", LW'(in_req_ready_o), '0);
    end

    // Reset while a request is stalled mid-handshake.
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    cmp("rst_cycle_ready", LW'(in_req_ready_o), '0);
    @(negedge clk);
    cmp("rst_out_valid", LW'(out_req_valid_o), '0);
    cmp("rst_rr", LW'(dut.r_rr), '0);
    cmp("rst_ready", LW'(in_req_ready_o), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_req_valid_i = '0;
    out_req_ready_i = 1'b1;

    // Same-line requests from ports 1 and 3.
    set_req(1, 1'b1, 32'h8000_0040, 8'h04);
    set_req(3, 1'b1, 32'h8000_0040, 8'h80);
    @(negedge clk);
    cmp("merge_ready1", LW'(in_req_ready_o), MERGE ? LW'(4'b1010) : LW'(4'b0010));
    @(posedge clk); #1;
    set_req(1, 1'b0, 32'h8000_0040, 8'h04);
    if (MERGE) set_req(3, 1'b0, 32'h8000_0040, 8'h80);
    @(negedge clk);
    cmp("merge_req1_valid", LW'(out_req_valid_o), LW'(1));
    cmp("merge_req1_id", LW'(out_req_id_o), MERGE ? LW'(8'h84) : LW'(8'h04));
    cmp("merge_ready2", LW'(in_req_ready_o), MERGE ? '0 : LW'(4'b1000));
    @(posedge clk); #1;
    in_req_valid_i = '0;
    @(negedge clk);
    cmp("merge_req2_valid", LW'(out_req_valid_o), MERGE ? '0 : LW'(1));
    if (out_req_valid_o) cmp("merge_req2_id", LW'(out_req_id_o), LW'(8'h80));
    @(posedge clk); #1;
    @(negedge clk);
    cmp("merge_idle", LW'(out_req_valid_o), '0);

    // Response demultiplexing.
    @(posedge clk); #1;
    out_rsp_id_i = 8'h84;
    out_rsp_valid_i = 1'b1;
    out_rsp_error_i = 1'b1;
    out_rsp_data_i = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
    in_rsp_ready_i = 4'b0111;
    @(negedge clk);
    cmp("rsp_valid", LW'(in_rsp_valid_o), LW'(4'b1010));
    cmp("rsp_id_p0", LW'(in_rsp_id_o[7:0]), '0);
    cmp("rsp_id_p1", LW'(in_rsp_id_o[15:8]), LW'(8'h04));
    cmp("rsp_id_p3", LW'(in_rsp_id_o[31:24]), LW'(8'h80));
    cmp("rsp_ready_blocked", LW'(out_rsp_ready_o), '0);
    cmp("rsp_data", in_rsp_data_o, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D);
    cmp("rsp_error", LW'(in_rsp_error_o), LW'(1));
    in_rsp_ready_i = 4'b1010;
    #1 cmp("rsp_ready_open", LW'(out_rsp_ready_o), LW'(1));
    out_rsp_id_i = 8'h00;
    in_rsp_ready_i = 4'b0000;
    #1 cmp("rsp_unaddressed_ready", LW'(out_rsp_ready_o), LW'(1));
    cmp("rsp_unaddressed_valid", LW'(in_rsp_valid_o), '0);

    // Randomized phase from a freshly reset arbiter.
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_rr = 0;
    m_held = 0;
    repeat (400) rand_cycle(1'b0);
    repeat (2) rand_cycle(1'b1);
    @(negedge clk); #1;
    sb_en = 1'b0;
    cmp("sb_req_left", LW'(req_q.size()), '0);
    cmp("sb_cyc_left", LW'(cyc_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
